cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Downstream observer for the single-cycle `cpu` core. It samples the core's program counter, ALU opcode and destination value each clock, and pushes one trace record into a DEPTH-entry FIFO whenever the PC changes. A host or bench drains the records through a valid/ready read port. The block also flags a halt when the PC stays unchanged for HALT_CYCLES consecutive cycles, so the end of a run is detected without a fixed simulation timeout.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `HALT_CYCLES`, 8: consecutive unchanged-PC cycles that declare a halt; at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_in`  in  32  core `pc_out`.
- `alu_op_in`  in  5  core `alu_op`.
- `rd_in`  in  32  core `rd` value.
- `trace_en`  in  1  capture enable.
- `rd_ready`  in  1  consumer accepts the head record.
- `rd_valid`  out  1  head record present.
- `rd_data`  out  69  head record `{pc[31:0], alu_op[4:0], rd[31:0]}`.
- `count`  out  $clog2(DEPTH)+1  entries currently held.
- `overflow`  out  1  sticky; a record was dropped.
- `drop_count`  out  16  dropped records; saturates at 16'hFFFF.
- `halted`  out  1  halt detected.

## Operation

- **FSM states:** IDLE, RUN, HALTED. State is held in registers.
  - IDLE → RUN when `trace_en`=1.
  - RUN → HALTED when `stable_cnt` reaches HALT_CYCLES-1 and `pc_in` == `last_pc`.
  - HALTED → RUN on the first `pc_in` != `last_pc`.
  - Any state → IDLE when `trace_en`=0. The FIFO contents are kept.
- **Registers:**
  - `last_pc` (32) holds the previous cycle's `pc_in`.
  - `pc_seen` (1) is cleared on reset and on entry to IDLE.
  - `stable_cnt` saturates at HALT_CYCLES-1.
  - In every cycle with `trace_en`=1, `last_pc` takes `pc_in` and `pc_seen` is set to 1.
- **Capture condition:** the state is not IDLE and `trace_en`=1, and either `pc_seen`=0 or `pc_in` != `last_pc`.
  - The pushed record is `{pc_in, alu_op_in, rd_in}` as sampled at that edge.
  - In the IDLE cycle where `trace_en` rises, no capture occurs. `last_pc` and `pc_seen` still update in that cycle.
- **stable_cnt:**
  - Cleared to 0 on any PC change, and while `pc_seen`=0.
  - Otherwise increments by 1.
- **`halted`** is 1 exactly when the state is HALTED.
- **FIFO** is first-word-fall-through, with wrap-around read and write pointers.
  - `rd_valid` = (`count` != 0).
  - `rd_data` is the head entry. It is don't-care when `rd_valid`=0.
  - A pop occurs when `rd_valid` and `rd_ready` are both 1.
- **Push and pop in the same cycle:**
  - Both are performed.
  - `count` is unchanged.
  - A push is accepted even when `count`=DEPTH, because the pop frees a slot.
- **Push while full with no pop:**
  - The record is dropped and the FIFO is unchanged.
  - `overflow` is set to 1.
  - `drop_count` increments, saturating.
- **Pop while empty:** ignored.
- **Overflow clearing:** `overflow` and `drop_count` clear only on reset.

## Timing

- **Reset (asynchronous, takes effect immediately):**
  - `state`=IDLE.
  - `count`=0, `rd_valid`=0, pointers=0.
  - `overflow`=0, `drop_count`=0, `halted`=0.
  - `last_pc`=0, `pc_seen`=0, `stable_cnt`=0.
  - `rd_data` reads 0.
  - A reset asserted mid-run discards all FIFO contents.
- **Capture latency:** a record captured at edge N has `rd_valid`=1 and `rd_data` valid after edge N. It can be popped at edge N+1 at the earliest.
- **Pop:** takes effect at the edge where `rd_valid` and `rd_ready` are both 1. The next record appears after that same edge.
- **Halt latency:** PC stable from edge K onward (`pc_in`==`last_pc` first true at edge K) gives `halted`=1 after edge K+HALT_CYCLES-1.
- **Halt exit:** `halted` deasserts after the first edge at which the PC differs. That edge also captures the new record.
- **Status outputs:** `count`, `overflow` and `drop_count` are registered and update at the same edge as the push or pop that changes them.

## Test plan

- **Basic capture:** reset, `trace_en`=1, PC sequence 0,4,8,8,12 with `rd_ready`=0 → `count`=4. Records drain in order with PCs 0,4,8,12 and matching `alu_op` and `rd` values.
- **Full + drop:** DEPTH=16 with 18 distinct PCs and no reads → `count`=16, `overflow`=1, `drop_count`=2. Drained PCs are the first 16.
- **Full + simultaneous pop:** FIFO full, new PC with `rd_ready`=1 → `count` stays 16, `overflow` stays 0, the new record lands at the tail.
- **Halt:** PC held at 0x40 for 8 cycles → `halted`=1 exactly 7 edges after the first repeat. PC then moves to 0x44 → `halted`=0 and a record for 0x44 is captured.
- **Enable gating:** `trace_en`=0 while the PC changes → no records. Re-enable with the PC at 0x10 → the first record is at the next distinct PC, not 0x10.
- **Reset mid-run:** 5 entries held and `overflow`=1, pulse `rst_n` low between edges → `count`=0, `rd_valid`=0, `overflow`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Trace observer for the single-cycle cpu core: records {pc, alu_op, rd} on every
// PC change into a first-word-fall-through FIFO and flags a halt on a stalled PC.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                pc_in,
    input  logic [4:0]                 alu_op_in,
    input  logic [31:0]                rd_in,
    input  logic                       trace_en,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [68:0]                rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(HALT_CYCLES);
    localparam int unsigned RW = 69;
    localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     last_pc;
    logic            pc_seen;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [RW-1:0]   mem [DEPTH];
    logic [CW-1:0]   count_next;

    logic            pc_changed;
    logic            capture;
    logic            pop;
    logic            full;
    logic            push;
    logic            drop;

    // Capture / FIFO handshake decode and next-state logic
    always_comb begin
        pc_changed  = (pc_in != last_pc);
        capture     = (state != IDLE) && trace_en && (!pc_seen || pc_changed);
        pop         = rd_valid && rd_ready;
        full        = (count == CW'(DEPTH));
        push        = capture && (!full || pop);
        drop        = capture && full && !pop;
        count_next  = count;
        state_next  = state;
        stable_next = stable_cnt;

        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        if (!pc_seen || pc_changed) begin
            stable_next = '0;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_next = stable_cnt + SW'(1);
        end

        if (!trace_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     if (stable_cnt == STABLE_MAX && !pc_changed) state_next = HALTED;
                HALTED:  if (pc_changed) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            halted     <= 1'b0;
            last_pc    <= '0;
            pc_seen    <= 1'b0;
            stable_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_next;
            halted     <= (state_next == HALTED);
            stable_cnt <= stable_next;
            // pc_seen can only be low while IDLE, so it simply follows the enable
            pc_seen    <= trace_en;
            if (trace_en) begin
                last_pc <= pc_in;
            end
            if (push) begin
                mem[wr_ptr] <= {pc_in, alu_op_in, rd_in};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            rd_valid <= (count_next != '0);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (DEPTH=16, HALT_CYCLES=8).
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic [4:0]  alu_op_in;
    logic [31:0] rd_in;
    logic        trace_en;
    logic        rd_ready;
    logic        rd_valid;
    logic [68:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    cpu_trace_buffer #(.DEPTH(16), .HALT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .alu_op_in  (alu_op_in),
        .rd_in      (rd_in),
        .trace_en   (trace_en),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [68:0] rec(input logic [31:0] pc);
        return {pc, pc[6:2], pc ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of core activity, then sample 1 ns after the edge
    task automatic step(input logic [31:0] pc, input logic en, input logic rdy);
        pc_in     = pc;
        alu_op_in = pc[6:2];
        rd_in     = pc ^ 32'hA5A5_0000;
        trace_en  = en;
        rd_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_in = '0; alu_op_in = '0; rd_in = '0; trace_en = 1'b0; rd_ready = 1'b0;
        #3;
        check("reset_count", 69'(count), 69'd0);
        check("reset_valid", 69'(rd_valid), 69'd0);
        check("reset_overflow", 69'(overflow), 69'd0);
        check("reset_drops", 69'(drop_count), 69'd0);
        check("reset_halted", 69'(halted), 69'd0);
        check("reset_data", rd_data, 69'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);

        // Basic capture: enabling edge never captures, repeated PC 8 is skipped
        step(32'hFFFF_FFF0, 1'b1, 1'b0);
        check("enable_edge_count", 69'(count), 69'd0);
        step(32'h0, 1'b1, 1'b0);
        check("first_capture_valid", 69'(rd_valid), 69'd1);
        check("first_capture_data", rd_data, rec(32'h0));
        step(32'h4, 1'b1, 1'b0);
        step(32'h8, 1'b1, 1'b0);
        step(32'h8, 1'b1, 1'b0);
        step(32'hC, 1'b1, 1'b0);
        check("basic_count", 69'(count), 69'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("basic_drain_%0d", i), rd_data, rec(32'(4 * i)));
            step(32'hC, 1'b1, 1'b1);
        end
        check("basic_empty_count", 69'(count), 69'd0);
        check("basic_empty_valid", 69'(rd_valid), 69'd0);

        // Fill to DEPTH, then push+pop while full, then two drops
        for (int i = 0; i < 16; i++) step(32'h100 + 32'(4 * i), 1'b1, 1'b0);
        check("full_count", 69'(count), 69'd16);
        check("full_no_overflow", 69'(overflow), 69'd0);
        step(32'h140, 1'b1, 1'b1);
        check("full_pushpop_count", 69'(count), 69'd16);
        check("full_pushpop_overflow", 69'(overflow), 69'd0);
        check("full_pushpop_head", rd_data, rec(32'h104));
        step(32'h144, 1'b1, 1'b0);
        step(32'h148, 1'b1, 1'b0);
        check("drop_count_val", 69'(count), 69'd16);
        check("drop_overflow", 69'(overflow), 69'd1);
        check("drop_drops", 69'(drop_count), 69'd2);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_drain_%0d", i), rd_data, rec(32'h104 + 32'(4 * i)));
            step(32'h148, 1'b1, 1'b1);
        end
        check("full_drained", 69'(count), 69'd0);

        // Halt: 0x40 first repeats at edge K, halted rises after edge K+7
        step(32'h3C, 1'b1, 1'b0);
        check("halt_exit_on_change", 69'(halted), 69'd0);
        step(32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(32'h40, 1'b1, 1'b0);
        check("halt_not_yet", 69'(halted), 69'd0);
        step(32'h40, 1'b1, 1'b0);
        check("halt_set", 69'(halted), 69'd1);
        step(32'h40, 1'b1, 1'b0);
        check("halt_held", 69'(halted), 69'd1);
        step(32'h44, 1'b1, 1'b0);
        check("halt_cleared", 69'(halted), 69'd0);
        check("halt_count", 69'(count), 69'd3);
        check("halt_head", rd_data, rec(32'h3C));
        step(32'h44, 1'b1, 1'b1);
        step(32'h44, 1'b1, 1'b1);
        check("halt_tail_record", rd_data, rec(32'h44));
        step(32'h44, 1'b1, 1'b1);
        check("halt_drained", 69'(count), 69'd0);

        // Enable gating: no capture while disabled, none on the re-enable PC
        step(32'h50, 1'b0, 1'b0);
        step(32'h60, 1'b0, 1'b0);
        step(32'h70, 1'b0, 1'b0);
        check("gated_count", 69'(count), 69'd0);
        step(32'h10, 1'b1, 1'b0);
        step(32'h10, 1'b1, 1'b0);
        check("reenable_count", 69'(count), 69'd0);
        step(32'h14, 1'b1, 1'b0);
        check("reenable_capture_count", 69'(count), 69'd1);
        check("reenable_capture_data", rd_data, rec(32'h14));
        step(32'h14, 1'b1, 1'b1);

        // Reset mid-run with 5 entries held and overflow set
        for (int i = 0; i < 17; i++) step(32'h800 + 32'(4 * i), 1'b1, 1'b0);
        check("pre_reset_drops", 69'(drop_count), 69'd3);
        for (int i = 0; i < 11; i++) step(32'h840, 1'b1, 1'b1);
        check("pre_reset_count", 69'(count), 69'd5);
        check("pre_reset_overflow", 69'(overflow), 69'd1);
        check("pre_reset_head", rd_data, rec(32'h82C));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_count", 69'(count), 69'd0);
        check("async_reset_valid", 69'(rd_valid), 69'd0);
        check("async_reset_overflow", 69'(overflow), 69'd0);
        check("async_reset_drops", 69'(drop_count), 69'd0);
        check("async_reset_halted", 69'(halted), 69'd0);
        check("async_reset_data", rd_data, 69'd0);
        #2 rst_n = 1'b1;
        step(32'h900, 1'b1, 1'b0);
        check("post_reset_enable_edge", 69'(count), 69'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
